text_console_writer: RTL
========================

TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 SHALL have parameter COLUMNS, default 80, meaning characters per text row.
REQ-002 SHALL have parameter ROWS, default 30, meaning text rows on screen.
REQ-003 SHALL have parameter BLANK, default 8'h20, meaning the character code used to clear cells.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low; one clock only.
REQ-006 SHALL have port i_valid  input  1  character offered on i_char.
REQ-007 SHALL have port i_char  input  8  character or control code.
REQ-008 SHALL have port o_ready  output  1  block accepts i_char this cycle.
REQ-009 SHALL have port o_we  output  1  text RAM write strobe, one cycle per cell.
REQ-010 SHALL have port o_addr  output  12  text RAM address, row*COLUMNS+col.
REQ-011 SHALL have port o_data  output  8  text RAM write data.
REQ-012 SHALL have port o_col  output  7  current cursor column.
REQ-013 SHALL have port o_row  output  5  current cursor row.

Function
REQ-014 SHALL implement states CLR_ALL, IDLE, PUT, CLR_LINE; o_ready high only in IDLE.
REQ-015 SHALL accept a character only when i_valid and o_ready are both high (transfer cycle N), register it, and go to PUT at N+1.
REQ-016 SHALL, in PUT, classify the registered character: printable 0x20-0x7E, LF 0x0A, CR 0x0D, BS 0x08, FF 0x0C, all others ignored.
REQ-017 SHALL, for printable, assert o_we in cycle N+1 with o_addr = cursor address and o_data = char, then advance col by 1.
REQ-018 SHALL, when a printable is written at col COLUMNS-1, set col 0, increment row, and enter CLR_LINE.
REQ-019 SHALL, for LF, set col 0, increment row, and enter CLR_LINE without writing in PUT.
REQ-020 SHALL increment row modulo ROWS (row ROWS-1 wraps to 0); no scrolling.
REQ-021 SHALL, for CR, set col 0, no write, return to IDLE.
REQ-022 SHALL, for BS with col>0, decrement col and write BLANK at the new cursor address in PUT; with col 0, no write, no cursor change.
REQ-023 SHALL, for FF, set cursor (0,0) and enter CLR_ALL.
REQ-024 SHALL, for ignored codes, perform no write and return to IDLE at N+2.
REQ-025 SHALL, in CLR_LINE, write BLANK to addresses row*COLUMNS .. row*COLUMNS+COLUMNS-1, one per cycle in ascending order, then enter IDLE.
REQ-026 SHALL, in CLR_ALL, write BLANK to addresses 0 .. ROWS*COLUMNS-1 (0..2399), one per cycle ascending, then enter IDLE with cursor (0,0).
REQ-027 SHALL keep o_we low in IDLE and in PUT for non-writing codes; o_addr/o_data are don't-care when o_we low.
REQ-028 SHALL never produce o_addr >= ROWS*COLUMNS.
REQ-029 SHALL update o_col/o_row registered, reflecting the new cursor the cycle after PUT.
REQ-030 SHALL ignore i_valid while o_ready is low; the source holds i_char until transfer.

Reset
REQ-031 SHALL, while rst_n is low at a clock edge, force o_we=0, o_ready=0, cursor (0,0), clear counter 0, state CLR_ALL.
REQ-032 SHALL, on the first cycle after rst_n returns high, assert o_we with o_addr=0, o_data=BLANK, and complete the full clear (2400 writes) before o_ready rises.
REQ-033 SHALL abandon any PUT, CLR_LINE or CLR_ALL in progress when rst_n is sampled low and restart CLR_ALL from address 0.

Verification
REQ-034 Reset released -> exactly 2400 o_we pulses, addresses 0..2399, data 0x20; then o_ready=1, o_col=0, o_row=0.
REQ-035 Send 'A' (0x41) at cursor (0,0) -> one write addr 0 data 0x41 the cycle after transfer; o_col=1; o_ready high 2 cycles after transfer.
REQ-036 Send 80 printables from (0,2) -> writes 160..239, then 80 BLANK writes to 240..319, cursor (0,3).
REQ-037 Cursor (5,29), send LF -> no PUT write, 80 BLANK writes to 2320..2399? no: row wraps to 0, writes 0..79, cursor (0,0).
REQ-038 Cursor (3,4), send BS -> write addr 322 data 0x20, o_col=2; then BS at col 0 -> no write; CR and 0x07 -> no write.
REQ-039 Assert rst_n low midway through a CLR_LINE -> after release, CLR_ALL restarts at address 0 and cursor is (0,0).

Source files
------------

// File: rtl/text_console_writer.sv
// Character-stream text console writer: turns printable characters and the
// LF/CR/BS/FF control codes into single-cell writes and line/screen clears.
module text_console_writer #(
   parameter int unsigned COLUMNS = 80,
   parameter int unsigned ROWS    = 30,
   parameter logic [7:0]  BLANK   = 8'h20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_valid,
   input  logic [7:0]  i_char,
   output logic        o_ready,
   output logic        o_we,
   output logic [11:0] o_addr,
   output logic [7:0]  o_data,
   output logic [6:0]  o_col,
   output logic [4:0]  o_row
);

   localparam int unsigned AW    = 12;
   localparam int unsigned CW    = 7;
   localparam int unsigned RW    = 5;
   localparam int unsigned CELLS = ROWS * COLUMNS;

   localparam logic [7:0] CH_BS = 8'h08;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_FF = 8'h0C;
   localparam logic [7:0] CH_CR = 8'h0D;

   typedef enum logic [1:0] {
      CLR_ALL  = 2'd0,
      IDLE     = 2'd1,
      PUT      = 2'd2,
      CLR_LINE = 2'd3
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   col_q;
   logic [RW-1:0]   row_q;
   logic [7:0]      char_q;
   logic [AW-1:0]   cnt_q;
   logic            we_q;
   logic [AW-1:0]   addr_q;
   logic [7:0]      data_q;
   logic            ready_q;

   logic [AW-1:0]   line_base;
   logic [AW-1:0]   cur_addr;
   logic [RW-1:0]   row_inc;
   logic            col_last;
   logic            in_print;
   logic            q_print;

   function automatic logic is_print(input logic [7:0] ch);
      return (ch >= 8'h20) && (ch <= 8'h7E);
   endfunction

   // Cursor address and row-advance helpers derived from the cursor registers.
   assign line_base = AW'(row_q * COLUMNS);
   assign cur_addr  = line_base + AW'(col_q);
   assign row_inc   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
   assign col_last  = (col_q == CW'(COLUMNS - 1));
   assign in_print  = is_print(i_char);
   assign q_print   = is_print(char_q);

   // Outputs are registered alongside the state so the write strobe lines up
   // with the cycle the state register describes (PUT, or each clear cycle).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= CLR_ALL;
         col_q   <= '0;
         row_q   <= '0;
         char_q  <= '0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= BLANK;
         ready_q <= 1'b0;
      end else begin
         we_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_valid && ready_q) begin
                  char_q  <= i_char;
                  ready_q <= 1'b0;
                  state_q <= PUT;
                  if (in_print) begin
                     we_q   <= 1'b1;
                     addr_q <= cur_addr;
                     data_q <= i_char;
                  end else if ((i_char == CH_BS) && (col_q != '0)) begin
                     we_q   <= 1'b1;
                     addr_q <= cur_addr - AW'(1);
                     data_q <= BLANK;
                  end
               end
            end

            PUT: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
               if (q_print) begin
                  if (col_last) begin
                     col_q   <= '0;
                     row_q   <= row_inc;
                     cnt_q   <= '0;
                     ready_q <= 1'b0;
                     state_q <= CLR_LINE;
                  end else begin
                     col_q <= col_q + CW'(1);
                  end
               end else begin
                  case (char_q)
                     CH_LF: begin
                        col_q   <= '0;
                        row_q   <= row_inc;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= CLR_LINE;
                     end
                     CH_CR: col_q <= '0;
                     CH_BS: begin
                        if (col_q != '0) col_q <= col_q - CW'(1);
                     end
                     CH_FF: begin
                        col_q   <= '0;
                        row_q   <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= CLR_ALL;
                     end
                     default: ;
                  endcase
               end
            end

            // cnt_q is the column of the next blank to issue on the cursor row.
            CLR_LINE: begin
               if (cnt_q < AW'(COLUMNS)) begin
                  we_q   <= 1'b1;
                  addr_q <= line_base + cnt_q;
                  data_q <= BLANK;
                  cnt_q  <= cnt_q + AW'(1);
               end else begin
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end

            // cnt_q is the next screen address to blank.
            CLR_ALL: begin
               if (cnt_q < AW'(CELLS)) begin
                  we_q   <= 1'b1;
                  addr_q <= cnt_q;
                  data_q <= BLANK;
                  cnt_q  <= cnt_q + AW'(1);
               end else begin
                  col_q   <= '0;
                  row_q   <= '0;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end

            default: begin
               cnt_q   <= '0;
               ready_q <= 1'b0;
               state_q <= CLR_ALL;
            end
         endcase
      end
   end

   assign o_ready = ready_q;
   assign o_we    = we_q;
   assign o_addr  = addr_q;
   assign o_data  = data_q;
   assign o_col   = col_q;
   assign o_row   = row_q;

endmodule
